// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between fetch, load/store, the port arbiter and the memory interconnect.
interface mem_port_arbiter_if;
  logic        i_I_REQ;
  logic [31:0] i_I_ADDR;
  logic        o_I_ACK;
  logic [31:0] o_I_DATA;
  logic        o_I_ERR;
  logic        i_D_REQ;
  logic        i_D_WE;
  logic [31:0] i_D_ADDR;
  logic [31:0] i_D_WDATA;
  logic [3:0]  i_D_BE;
  logic        o_D_ACK;
  logic [31:0] o_D_RDATA;
  logic        o_D_ERR;
  logic        o_M_REQ;
  logic        o_M_WE;
  logic [31:0] o_M_ADDR;
  logic [31:0] o_M_WDATA;
  logic [3:0]  o_M_BE;
  logic        i_M_ACK;
  logic [31:0] i_M_RDATA;

  modport slave (
    input  i_I_REQ, i_I_ADDR, i_D_REQ, i_D_WE, i_D_ADDR, i_D_WDATA, i_D_BE, i_M_ACK, i_M_RDATA,
    output o_I_ACK, o_I_DATA, o_I_ERR, o_D_ACK, o_D_RDATA, o_D_ERR,
           o_M_REQ, o_M_WE, o_M_ADDR, o_M_WDATA, o_M_BE
  );

  modport master (
    output i_I_REQ, i_I_ADDR, i_D_REQ, i_D_WE, i_D_ADDR, i_D_WDATA, i_D_BE, i_M_ACK, i_M_RDATA,
    input  o_I_ACK, o_I_DATA, o_I_ERR, o_D_ACK, o_D_RDATA, o_D_ERR,
           o_M_REQ, o_M_WE, o_M_ADDR, o_M_WDATA, o_M_BE
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for the single memory port: request->o_M_REQ in 1 cycle, ACK 1 cycle after i_M_ACK,
// one transaction in flight; requesters hold REQ until ACK, the watchdog aborts a stalled memory with ERR.
module mem_port_arbiter #(
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  mem_port_arbiter_if.slave io_bus
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);
  localparam logic [7:0] TMO_LAST   = (TIMEOUT_CYC == 0) ? 8'd0 : 8'(TIMEOUT_CYC - 1);
  localparam bit         TMO_EN     = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_owner;
  logic [3:0]  r_streak;
  logic [7:0]  r_tmo;
  logic        r_m_req;
  logic        r_m_we;
  logic [31:0] r_m_addr;
  logic [31:0] r_m_wdata;
  logic [3:0]  r_m_be;
  logic        r_i_ack;
  logic        r_i_err;
  logic [31:0] r_i_data;
  logic        r_d_ack;
  logic        r_d_err;
  logic [31:0] r_d_rdata;
  logic        w_grant;
  logic        w_grant_d;
  logic        w_end;
  logic        w_ok;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_d   = 1'b0;
    w_end       = 1'b0;
    w_ok        = 1'b0;
    case (r_state)
      IDLE: begin
        if (io_bus.i_I_REQ || io_bus.i_D_REQ) begin
          w_grant     = 1'b1;
          // Data has priority until it has won MAX_DSTREAK times in a row over a waiting fetch.
          w_grant_d   = io_bus.i_D_REQ && !(io_bus.i_I_REQ && (r_streak == STREAK_MAX));
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (io_bus.i_M_ACK) begin
          w_end       = 1'b1;
          w_ok        = 1'b1;
          w_state_nxt = RESP;
        end else if (TMO_EN && (r_tmo == TMO_LAST)) begin
          w_end       = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_owner   <= 1'b0;
      r_streak  <= 4'd0;
      r_tmo     <= 8'd0;
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= 32'd0;
      r_m_wdata <= 32'd0;
      r_m_be    <= 4'd0;
      r_i_ack   <= 1'b0;
      r_i_err   <= 1'b0;
      r_i_data  <= 32'd0;
      r_d_ack   <= 1'b0;
      r_d_err   <= 1'b0;
      r_d_rdata <= 32'd0;
    end else begin
      if (r_state == RESP) begin
        r_i_ack <= 1'b0;
        r_d_ack <= 1'b0;
      end
      if (r_state == BUSY) begin
        r_tmo <= r_tmo + 8'd1;
      end
      if (w_grant) begin
        r_owner <= w_grant_d;
        r_m_req <= 1'b1;
        r_tmo   <= 8'd0;
        if (w_grant_d) begin
          r_m_we    <= io_bus.i_D_WE;
          r_m_addr  <= io_bus.i_D_ADDR;
          r_m_wdata <= io_bus.i_D_WDATA;
          r_m_be    <= io_bus.i_D_BE;
          if (!io_bus.i_I_REQ) begin
            r_streak <= 4'd0;
          end else if (r_streak != STREAK_MAX) begin
            r_streak <= r_streak + 4'd1;
          end
        end else begin
          r_m_we    <= 1'b0;
          r_m_addr  <= io_bus.i_I_ADDR;
          r_m_wdata <= 32'd0;
          r_m_be    <= 4'hF;
          r_streak  <= 4'd0;
        end
      end
      if (w_end) begin
        r_m_req <= 1'b0;
        if (r_owner) begin
          r_d_ack   <= 1'b1;
          r_d_err   <= !w_ok;
          r_d_rdata <= w_ok ? io_bus.i_M_RDATA : 32'd0;
        end else begin
          r_i_ack  <= 1'b1;
          r_i_err  <= !w_ok;
          r_i_data <= w_ok ? io_bus.i_M_RDATA : 32'd0;
        end
      end
    end
  end

  assign io_bus.o_M_REQ   = r_m_req;
  assign io_bus.o_M_WE    = r_m_we;
  assign io_bus.o_M_ADDR  = r_m_addr;
  assign io_bus.o_M_WDATA = r_m_wdata;
  assign io_bus.o_M_BE    = r_m_be;
  assign io_bus.o_I_ACK   = r_i_ack;
  assign io_bus.o_I_ERR   = r_i_err;
  assign io_bus.o_I_DATA  = r_i_data;
  assign io_bus.o_D_ACK   = r_d_ack;
  assign io_bus.o_D_ERR   = r_d_err;
  assign io_bus.o_D_RDATA = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a transaction-timeline model.
module tb_mem_port_arbiter;
  localparam int MAXS = 4;
  localparam int TMO  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MAX_DSTREAK(MAXS), .TIMEOUT_CYC(TMO)) dut (
    .i_CLK (clk),
    .i_RST (rst),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // Model: edge index of the grant, owner, and the first edge at which arbitration may happen again.
  int  k = 0;
  bit  mb_busy;
  int  mb_from;
  bit  mb_owner;
  int  next_arb;
  int  dwins;
  bit  e_m_req, e_m_we, e_i_ack, e_i_err, e_d_ack, e_d_err;
  logic [31:0] e_m_addr, e_m_wdata, e_i_data, e_d_rdata;
  logic [3:0]  e_m_be;

  logic [31:0] dut_grants[$];
  logic        prev_mreq = 1'b0;
  int          cnt;
  int          gsz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%08h required=%08h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  task automatic model_reset();
    mb_busy = 1'b0; dwins = 0; next_arb = 0;
    e_m_req = 1'b0; e_m_we = 1'b0; e_m_addr = '0; e_m_wdata = '0; e_m_be = '0;
    e_i_ack = 1'b0; e_i_err = 1'b0; e_i_data = '0;
    e_d_ack = 1'b0; e_d_err = 1'b0; e_d_rdata = '0;
  endtask

  task automatic model_edge();
    bit ok;
    bit d;
    e_i_ack = 1'b0;
    e_d_ack = 1'b0;
    if (mb_busy) begin
      if (bus.i_M_ACK || (k - mb_from) == TMO) begin
        ok = bus.i_M_ACK;
        mb_busy = 1'b0;
        e_m_req = 1'b0;
        next_arb = k + 2;
        if (mb_owner) begin
          e_d_ack = 1'b1; e_d_err = !ok; e_d_rdata = ok ? bus.i_M_RDATA : 32'd0;
        end else begin
          e_i_ack = 1'b1; e_i_err = !ok; e_i_data = ok ? bus.i_M_RDATA : 32'd0;
        end
      end
    end else if (k >= next_arb && (bus.i_I_REQ || bus.i_D_REQ)) begin
      d = bus.i_D_REQ && !(bus.i_I_REQ && dwins == MAXS);
      dwins = (d && bus.i_I_REQ) ? dwins + 1 : 0;
      mb_busy = 1'b1; mb_from = k; mb_owner = d; e_m_req = 1'b1;
      if (d) begin
        e_m_we = bus.i_D_WE; e_m_addr = bus.i_D_ADDR; e_m_wdata = bus.i_D_WDATA; e_m_be = bus.i_D_BE;
      end else begin
        e_m_we = 1'b0; e_m_addr = bus.i_I_ADDR; e_m_wdata = 32'd0; e_m_be = 4'hF;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    if (rst) model_reset();
    else model_edge();
    #1;
    if (bus.o_M_REQ && !prev_mreq) dut_grants.push_back(bus.o_M_ADDR);
    prev_mreq = bus.o_M_REQ;
  endtask

  // Issue one request, ack it after lat cycles of o_M_REQ, and check grant and completion literally.
  task automatic xact(input bit is_d, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int lat, input logic [31:0] rdata);
    bus.i_M_ACK = 1'b0;
    if (is_d) begin
      bus.i_D_REQ = 1'b1; bus.i_D_WE = we; bus.i_D_ADDR = addr; bus.i_D_WDATA = wdata; bus.i_D_BE = be;
    end else begin
      bus.i_I_REQ = 1'b1; bus.i_I_ADDR = addr;
    end
    step();
    chkb("grant_req", bus.o_M_REQ, 1'b1);
    chk("grant_addr", bus.o_M_ADDR, addr);
    chkb("grant_we", bus.o_M_WE, is_d ? we : 1'b0);
    chk("grant_be", 32'(bus.o_M_BE), is_d ? 32'(be) : 32'hF);
    chk("grant_wdata", bus.o_M_WDATA, is_d ? wdata : 32'd0);
    repeat (lat - 1) step();
    bus.i_M_ACK = 1'b1; bus.i_M_RDATA = rdata;
    step();
    bus.i_M_ACK = 1'b0;
    if (is_d) bus.i_D_REQ = 1'b0;
    else bus.i_I_REQ = 1'b0;
    chkb("done_m_req", bus.o_M_REQ, 1'b0);
    if (is_d) begin
      chkb("d_ack", bus.o_D_ACK, 1'b1); chk("d_rdata", bus.o_D_RDATA, rdata); chkb("d_err", bus.o_D_ERR, 1'b0);
    end else begin
      chkb("i_ack", bus.o_I_ACK, 1'b1); chk("i_data", bus.o_I_DATA, rdata); chkb("i_err", bus.o_I_ERR, 1'b0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chkb("m_req", bus.o_M_REQ, e_m_req);
        if (e_m_req) begin
          chkb("m_we", bus.o_M_WE, e_m_we);
          chk("m_addr", bus.o_M_ADDR, e_m_addr);
          chk("m_wdata", bus.o_M_WDATA, e_m_wdata);
          chk("m_be", 32'(bus.o_M_BE), 32'(e_m_be));
        end
        chkb("i_ack", bus.o_I_ACK, e_i_ack);
        chkb("i_err", bus.o_I_ERR, e_i_err);
        chk("i_data", bus.o_I_DATA, e_i_data);
        chkb("d_ack", bus.o_D_ACK, e_d_ack);
        chkb("d_err", bus.o_D_ERR, e_d_err);
        chk("d_rdata", bus.o_D_RDATA, e_d_rdata);
        chkb("ack_excl", bus.o_I_ACK & bus.o_D_ACK, 1'b0);
      end
    end
  end

  initial begin
    bus.i_I_REQ = 1'b0; bus.i_I_ADDR = '0;
    bus.i_D_REQ = 1'b0; bus.i_D_WE = 1'b0; bus.i_D_ADDR = '0; bus.i_D_WDATA = '0; bus.i_D_BE = '0;
    bus.i_M_ACK = 1'b0; bus.i_M_RDATA = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chkb("rst_m_req", bus.o_M_REQ, 1'b0);
    chkb("rst_i_ack", bus.o_I_ACK, 1'b0);
    chkb("rst_d_ack", bus.o_D_ACK, 1'b0);
    chk("rst_m_addr", bus.o_M_ADDR, 32'd0);
    chk("rst_m_be", 32'(bus.o_M_BE), 32'd0);
    chk("rst_d_rdata", bus.o_D_RDATA, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    step();

    // Fetch only, memory answers two cycles after o_M_REQ
    xact(1'b0, 1'b0, 32'h0000_0100, 32'd0, 4'hF, 2, 32'h0050_0093);
    step();
    chkb("i_ack_pulse", bus.o_I_ACK, 1'b0);
    chk("i_data_hold", bus.o_I_DATA, 32'h0050_0093);

    // Contention with a one-cycle memory
    dut_grants.delete();
    bus.i_I_REQ = 1'b1; bus.i_I_ADDR = 32'h0000_0100;
    bus.i_D_REQ = 1'b1; bus.i_D_WE = 1'b0; bus.i_D_ADDR = 32'h2000_0000; bus.i_D_WDATA = '0; bus.i_D_BE = 4'hF;
    for (int i = 0; i < 200 && dut_grants.size() < 10; i++) begin
      bus.i_M_ACK = bus.o_M_REQ; bus.i_M_RDATA = $urandom;
      step();
    end
    chk("contention_count", 32'(dut_grants.size()), 32'd10);
    for (int i = 0; i < 10 && i < dut_grants.size(); i++)
      chk("grant_order", dut_grants[i], (i % 5 == 4) ? 32'h0000_0100 : 32'h2000_0000);
    bus.i_I_REQ = 1'b0; bus.i_D_REQ = 1'b0;
    repeat (6) begin
      bus.i_M_ACK = bus.o_M_REQ;
      step();
    end
    bus.i_M_ACK = 1'b0;

    // Store
    xact(1'b1, 1'b1, 32'h2000_0004, 32'hDEAD_BEEF, 4'b0011, 1, 32'h1234_5678);
    step(); step();

    // Watchdog on a data read
    bus.i_D_REQ = 1'b1; bus.i_D_WE = 1'b0; bus.i_D_ADDR = 32'h3000_0000; bus.i_D_BE = 4'hF;
    step();
    cnt = 0;
    for (int i = 0; i < 20 && !bus.o_D_ACK; i++) begin
      if (bus.o_M_REQ) cnt++;
      step();
    end
    bus.i_D_REQ = 1'b0;
    chk("tmo_req_cycles", 32'(cnt), 32'd8);
    chkb("tmo_d_ack", bus.o_D_ACK, 1'b1);
    chkb("tmo_d_err", bus.o_D_ERR, 1'b1);
    chk("tmo_d_rdata", bus.o_D_RDATA, 32'd0);
    step();
    bus.i_M_ACK = 1'b1; bus.i_M_RDATA = 32'hFFFF_FFFF;
    step();
    bus.i_M_ACK = 1'b0;
    chkb("stray_d_ack", bus.o_D_ACK, 1'b0);
    chkb("stray_i_ack", bus.o_I_ACK, 1'b0);
    step();

    // Asynchronous reset while BUSY
    bus.i_I_REQ = 1'b1; bus.i_I_ADDR = 32'h0000_0040;
    step();
    chkb("pre_rst_req", bus.o_M_REQ, 1'b1);
    step();
    #2 rst = 1'b1;
    #1 chkb("async_rst_req", bus.o_M_REQ, 1'b0);
    model_reset();
    bus.i_I_REQ = 1'b0;
    step(); step();
    chkb("rst_no_ack", bus.o_I_ACK, 1'b0);
    #2 rst = 1'b0;
    xact(1'b0, 1'b0, 32'h0000_0200, 32'd0, 4'hF, 3, 32'hCAFE_0001);
    step();

    // Back-to-back data requests
    gsz = dut_grants.size();
    xact(1'b1, 1'b0, 32'h5000_0000, 32'd0, 4'hF, 1, 32'h0000_AAAA);
    step();
    xact(1'b1, 1'b1, 32'h5000_0008, 32'h0000_0011, 4'hC, 1, 32'h0000_0000);
    step(); step();
    chk("b2b_grants", 32'(dut_grants.size() - gsz), 32'd2);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (bus.i_I_REQ) begin
        if (bus.o_I_ACK) begin
          if ($urandom_range(1, 0) == 1) bus.i_I_ADDR = $urandom;
          else bus.i_I_REQ = 1'b0;
        end
      end else if ($urandom_range(3, 0) == 0) begin
        bus.i_I_REQ = 1'b1; bus.i_I_ADDR = $urandom;
      end
      if (!bus.i_D_REQ || bus.o_D_ACK) begin
        if (bus.o_D_ACK && $urandom_range(1, 0) == 0) bus.i_D_REQ = 1'b0;
        else if (bus.o_D_ACK || $urandom_range(2, 0) == 0) begin
          bus.i_D_REQ = 1'b1; bus.i_D_WE = 1'($urandom_range(1, 0)); bus.i_D_ADDR = $urandom;
          bus.i_D_WDATA = $urandom; bus.i_D_BE = 4'($urandom_range(15, 0));
        end
      end
      if (bus.o_M_REQ) bus.i_M_ACK = ($urandom_range(3, 0) == 0);
      else bus.i_M_ACK = ($urandom_range(7, 0) == 0);
      bus.i_M_RDATA = $urandom;
      step();
    end
    bus.i_I_REQ = 1'b0; bus.i_D_REQ = 1'b0;
    repeat (20) begin
      bus.i_M_ACK = bus.o_M_REQ;
      step();
    end
    chkb("final_idle", bus.o_M_REQ, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
